// File: rtl/mole_controller.sv
// Whack-a-mole game sequencer: requests mole positions, times each mole,
// scores hits and counts misses until the game ends.
module mole_controller #(
   parameter int MOLE_TICKS = 8,
   parameter int GAP_TICKS  = 2,
   parameter int MAX_MISSES = 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_tick,
   input  logic       i_start,
   input  logic [7:0] i_whack,
   input  logic [2:0] i_mole_position,
   output logic       o_change_position,
   output logic       o_mole_up,
   output logic       o_hit,
   output logic       o_miss,
   output logic [7:0] o_score,
   output logic [3:0] o_misses,
   output logic       o_game_over
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_SETTLE,
      S_SHOW,
      S_GAP,
      S_OVER
   } state_e;

   state_e     state_q;
   logic [7:0] timer_q;
   logic [7:0] whack_q;
   logic [7:0] score_q;
   logic [3:0] misses_q;
   logic       hit_q;
   logic       miss_q;
   logic       chg_q;
   logic       up_q;
   logic       over_q;

   logic [7:0] edge_w;
   logic [7:0] pos_mask;
   logic       hit_w;
   logic       wrong_w;
   logic       tout_w;
   logic [3:0] misses_d;
   logic       final_w;

   always_comb begin
      edge_w   = i_whack & ~whack_q;
      pos_mask = 8'b1 << i_mole_position;
      hit_w    = |(edge_w & pos_mask);
      wrong_w  = |(edge_w & ~pos_mask);
      tout_w   = i_tick && (timer_q == 8'd1);
      misses_d = misses_q + 4'd1;
      final_w  = (misses_d == 4'(MAX_MISSES));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= 8'd0;
         whack_q  <= 8'hFF;
         score_q  <= 8'd0;
         misses_q <= 4'd0;
         hit_q    <= 1'b0;
         miss_q   <= 1'b0;
         chg_q    <= 1'b0;
         up_q     <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         whack_q <= i_whack;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         chg_q   <= 1'b0;
         unique case (state_q)
            S_IDLE, S_OVER: begin
               if (i_start) begin
                  score_q  <= 8'd0;
                  misses_q <= 4'd0;
                  over_q   <= 1'b0;
                  state_q  <= S_REQ;
               end
            end
            S_REQ: begin
               chg_q   <= 1'b1;
               state_q <= S_SETTLE;
            end
            S_SETTLE: begin
               timer_q <= 8'(MOLE_TICKS);
               up_q    <= 1'b1;
               state_q <= S_SHOW;
            end
            S_SHOW: begin
               if (hit_w) begin
                  hit_q   <= 1'b1;
                  if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                  up_q    <= 1'b0;
                  timer_q <= 8'(GAP_TICKS);
                  state_q <= S_GAP;
               end else if (tout_w || wrong_w) begin
                  // a timeout takes the mole down; a wrong hole leaves it up
                  miss_q   <= 1'b1;
                  misses_q <= misses_d;
                  if (final_w) begin
                     up_q    <= 1'b0;
                     over_q  <= 1'b1;
                     state_q <= S_OVER;
                  end else if (tout_w) begin
                     up_q    <= 1'b0;
                     timer_q <= 8'(GAP_TICKS);
                     state_q <= S_GAP;
                  end
               end else if (i_tick) begin
                  timer_q <= timer_q - 8'd1;
               end
            end
            S_GAP: begin
               if (i_tick) begin
                  if (timer_q == 8'd1) state_q <= S_REQ;
                  else timer_q <= timer_q - 8'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_change_position = chg_q;
   assign o_mole_up         = up_q;
   assign o_hit             = hit_q;
   assign o_miss            = miss_q;
   assign o_score           = score_q;
   assign o_misses          = misses_q;
   assign o_game_over       = over_q;

endmodule

// File: tb/tb_mole_controller.sv
// Randomized and directed game sessions for mole_controller, checked by a
// scoreboard of predicted output events against a game-level model.
module tb_mole_controller;

   localparam int MT   = 8;
   localparam int GT   = 2;
   localparam int MAXM = 3;

   localparam int K_CHG  = 1;
   localparam int K_HIT  = 2;
   localparam int K_MISS = 4;
   localparam int K_UP   = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_tick = 1'b0;
   logic       i_start = 1'b0;
   logic [7:0] i_whack = 8'hFF;
   logic [2:0] i_mole_position = 3'd0;
   logic       o_change_position;
   logic       o_mole_up;
   logic       o_hit;
   logic       o_miss;
   logic [7:0] o_score;
   logic [3:0] o_misses;
   logic       o_game_over;

   mole_controller #(
      .MOLE_TICKS(MT),
      .GAP_TICKS (GT),
      .MAX_MISSES(MAXM)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_tick           (i_tick),
      .i_start          (i_start),
      .i_whack          (i_whack),
      .i_mole_position  (i_mole_position),
      .o_change_position(o_change_position),
      .o_mole_up        (o_mole_up),
      .o_hit            (o_hit),
      .o_miss           (o_miss),
      .o_score          (o_score),
      .o_misses         (o_misses),
      .o_game_over      (o_game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int kind;
      int score;
      int misses;
      bit go;
   } ev_t;

   ev_t exq[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // game-level model: 0 no game, 1 waiting for a mole, 2 mole up, 3 pause
   int         m_mode = 0;
   int         m_show_start = -1;
   int         m_left = 0;
   int         m_score = 0;
   int         m_misses = 0;
   bit         m_go = 1'b0;
   logic [7:0] m_prev = 8'hFF;

   function automatic void push(int c, int k);
      exq.push_back('{c, k, m_score, m_misses, m_go});
   endfunction

   function automatic void model_reset();
      m_mode = 0;
      m_show_start = -1;
      m_left = 0;
      m_score = 0;
      m_misses = 0;
      m_go = 1'b0;
      m_prev = 8'hFF;
      exq.delete();
   endfunction

   function automatic void new_mole(int c);
      m_mode = 1;
      m_show_start = c + 3;
      push(c + 2, K_CHG);
      push(c + 3, K_UP);
   endfunction

   function automatic void model(bit tk, bit st, logic [7:0] wh,
                                 logic [2:0] pos, int c);
      logic [7:0] e;
      e = wh & ~m_prev;
      m_prev = wh;
      case (m_mode)
         0: if (st) begin
            m_score = 0;
            m_misses = 0;
            m_go = 1'b0;
            new_mole(c);
         end
         1: if (c == m_show_start - 1) begin
            m_mode = 2;
            m_left = MT;
         end
         2: begin
            if (e[pos]) begin
               m_score = (m_score < 255) ? m_score + 1 : 255;
               m_mode = 3;
               m_left = GT;
               push(c + 1, K_HIT);
            end else if ((tk && m_left == 1) || e != 8'h00) begin
               m_misses++;
               if (m_misses == MAXM) begin
                  m_go = 1'b1;
                  m_mode = 0;
               end else if (tk && m_left == 1) begin
                  m_mode = 3;
                  m_left = GT;
               end
               push(c + 1, K_MISS);
            end else if (tk) begin
               m_left--;
            end
         end
         default: if (tk) begin
            if (m_left == 1) new_mole(c);
            else m_left--;
         end
      endcase
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit tk, input bit st, input logic [7:0] wh);
      @(posedge clk);
      #1;
      i_tick = tk;
      i_start = st;
      i_whack = wh;
      model(tk, st, wh, i_mole_position, cyc);
      if (m_mode == 2 && cyc == m_show_start - 1)
         i_mole_position = 3'($urandom_range(0, 7));
   endtask

   task automatic wait_show();
      int i;
      for (i = 0; i < 200 && m_mode != 2; i++)
         step(m_mode == 3, m_mode == 0, 8'h00);
      if (m_mode != 2) chk("wait_show_timeout", i, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_chg", int'(o_change_position), 0);
      chk("rst_up", int'(o_mole_up), 0);
      chk("rst_hit", int'(o_hit), 0);
      chk("rst_miss", int'(o_miss), 0);
      chk("rst_score", int'(o_score), 0);
      chk("rst_misses", int'(o_misses), 0);
      chk("rst_over", int'(o_game_over), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // monitor: every output event must match the head of the expectation queue
   initial begin
      bit   prev_up;
      logic [3:0] act;
      ev_t  e;
      prev_up = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_up = 1'b0;
         end else begin
            act = {o_mole_up & ~prev_up, o_miss, o_hit, o_change_position};
            prev_up = o_mole_up;
            while (exq.size() != 0 && exq[0].cyc < cyc) begin
               e = exq.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_event: kind %0d due cycle %0d not seen",
                        e.kind, e.cyc);
            end
            if (act != 4'd0) begin
               n_cmp++;
               if (exq.size() == 0) begin
                  n_bad++;
                  $display("FAIL unexpected_event: kind %0d at cycle %0d",
                           act, cyc);
               end else begin
                  e = exq.pop_front();
                  if (e.cyc != cyc || e.kind != int'(act) ||
                      e.score != int'(o_score) ||
                      e.misses != int'(o_misses) ||
                      e.go != o_game_over) begin
                     n_bad++;
                     $display("FAIL event: got cyc %0d kind %0d score %0d misses %0d over %0d, expected cyc %0d kind %0d score %0d misses %0d over %0d",
                              cyc, act, o_score, o_misses, o_game_over,
                              e.cyc, e.kind, e.score, e.misses, e.go);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] wh;
      int         p;
      bit         tk;
      model_reset();
      rst_n = 1'b0;
      i_whack = 8'hFF;
      do_reset();

      // buttons held through reset into the first mole: no edges
      step(0, 1, 8'hFF);
      repeat (10) step(0, 0, 8'hFF);
      chk("held_up", int'(o_mole_up), 1);
      chk("held_score", int'(o_score), 0);
      chk("held_misses", int'(o_misses), 0);

      // clean hit, then the pause and the next request
      step(0, 0, 8'h00);
      step(0, 0, 8'b1 << i_mole_position);
      step(0, 0, 8'h00);
      wait_show();

      // wrong hole held, then the right hole
      p = (int'(i_mole_position) + 1) % 8;
      wh = 8'b1 << p;
      repeat (3) step(0, 0, wh);
      wh = wh | (8'b1 << i_mole_position);
      step(0, 0, wh);
      step(0, 0, wh);
      chk("wrong_then_hit_misses", int'(o_misses), 1);
      step(0, 0, 8'h00);
      wait_show();

      // correct edge on the final tick
      repeat (MT - 1) step(1, 0, 8'h00);
      step(1, 0, 8'b1 << i_mole_position);
      step(0, 0, 8'h00);
      chk("tie_misses", int'(o_misses), 1);

      // reset while a position request is in flight
      step(1, 0, 8'h00);
      step(1, 0, 8'h00);
      do_reset();
      repeat (6) step(0, 0, 8'h00);
      chk("post_reset_up", int'(o_mole_up), 0);

      // three timeouts end the game; restart clears the counters
      step(0, 1, 8'h00);
      wait_show();
      for (int i = 0; i < 200 && !m_go; i++) step(1, 0, 8'h00);
      step(0, 0, 8'h00);
      chk("over_flag", int'(o_game_over), 1);
      chk("over_misses", int'(o_misses), MAXM);
      step(0, 1, 8'h00);
      step(0, 0, 8'h00);
      chk("restart_misses", int'(o_misses), 0);
      chk("restart_score", int'(o_score), 0);

      // random play
      for (int i = 0; i < 3000; i++) begin
         tk = ($urandom_range(0, 2) == 0);
         wh = i_whack;
         if (!tk && $urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: wh = wh | (8'b1 << i_mole_position);
               1: wh = wh | (8'b1 << $urandom_range(0, 7));
               2: wh = wh & ~(8'b1 << $urandom_range(0, 7));
               default: wh = 8'h00;
            endcase
         end
         step(tk, $urandom_range(0, 40) == 0, wh);
      end

      // score saturation
      do_reset();
      step(0, 1, 8'h00);
      for (int i = 0; i < 260; i++) begin
         wait_show();
         step(0, 0, 8'b1 << i_mole_position);
         step(0, 0, 8'h00);
      end
      step(0, 0, 8'h00);
      chk("score_saturated", int'(o_score), 255);

      repeat (10) step(0, 0, 8'h00);
      chk("queue_drained", exq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
